// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: serial line in, received byte and status strobes out.
// master is the receiver; slave is the pin driver plus the byte consumer.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] dataOut;
  logic       valid;
  logic       frameError;
  logic       parityError;
  logic       busy;

  modport master (input uart_rx, output dataOut, valid, frameError, parityError, busy);
  modport slave  (output uart_rx, input dataOut, valid, frameError, parityError, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLOCK_SPEED = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input logic      clock,
  input logic      reset,
  uart_rx_if.master bus
);

  localparam int          CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST    = 32'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLOCK_SPEED / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic        sync_p0;
  logic        sync_p1;
  logic [31:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_p0;
  logic [7:0]  data_out;
  logic        valid_r;
  logic        frame_err;
  logic        busy_r;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        par_err;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      data_out  <= 8'h00;
      valid_r   <= 1'b0;
      frame_err <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      // synchronizer stage boundary: sync_p1 is the only view of the line used below
      sync_p0   <= bus.uart_rx;
      sync_p1   <= sync_p0;
      valid_r   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!sync_p1) begin
            state   <= START;
            busy_r  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (sync_p1) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt           <= '0;
            shift_p0[bit_idx] <= sync_p1;
            bit_idx           <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bit <= sync_p1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end
`endif
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (sync_p1) begin
              // leave mid-stop-bit so a back-to-back start edge is not missed
              state  <= IDLE;
              busy_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (^{shift_p0, par_bit}) begin
                par_err <= 1'b1;
              end else begin
                valid_r  <= 1'b1;
                data_out <= shift_p0;
              end
`else
              valid_r  <= 1'b1;
              data_out <= shift_p0;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end
        WAIT_HIGH: begin
          if (sync_p1) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut    = data_out;
  assign bus.valid      = valid_r;
  assign bus.frameError = frame_err;
  assign bus.busy       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parityError = par_err;
`else
  assign bus.parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 16 clocks per bit.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;
  localparam int CLOCK_SPEED = 1600;
  localparam int BAUD_RATE   = 100;
  localparam int CPB         = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif
  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  uart_rx_if bus();

  uart_rx #(.CLOCK_SPEED(CLOCK_SPEED), .BAUD_RATE(BAUD_RATE)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    int   n;
    int   k;
    int   lat;
    exp_t e;
    logic prev;
    if (reset) begin
      prev = 1'b0;
    end else begin
      n = int'(bus.valid) + int'(bus.frameError) + int'(bus.parityError);
      if (n != 0) begin
        chk("strobe_exclusive", n, 1);
        chk("strobe_not_consecutive", prev, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b frameError=%0b parityError=%0b, expected none",
                   bus.valid, bus.frameError, bus.parityError);
        end else begin
          e = sb.pop_front();
          k = bus.valid ? EV_VALID : (bus.frameError ? EV_FERR : EV_PERR);
          chk("event_kind", k, e.kind);
          chk("dataOut_at_strobe", bus.dataOut, e.data);
          lat = cyc - e.t0;
          checks++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL strobe_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
          end
        end
      end
      prev = (n != 0);
    end
  end

  // Reference model: outcome of a frame from its bit values alone.
  function automatic exp_t predict(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e.t0 = cyc;
    if (!stop) begin
      e.kind = EV_FERR;
      e.data = last_good;
    end else begin
`ifdef UART_RX_PARITY_EN
      if (((^d) ^ par) != 1'b0) begin
        e.kind = EV_PERR;
        e.data = last_good;
        return e;
      end
`endif
      e.kind = EV_VALID;
      e.data = d;
    end
    return e;
  endfunction

  task automatic drive_bit(input logic v);
    bus.uart_rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic idle(input int n);
    bus.uart_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e = predict(d, stop, par);
    sb.push_back(e);
    if (e.kind == EV_VALID) last_good = d;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         gap;
    logic [7:0] c3;

    bus.uart_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_dataOut", bus.dataOut, 8'h00);
    chk("reset_valid", bus.valid, 0);
    chk("reset_frameError", bus.frameError, 0);
    chk("reset_parityError", bus.parityError, 0);
    chk("reset_busy", bus.busy, 0);
    reset = 1'b0;
    idle(5);

    send(8'hA5, 1'b1, ^8'hA5);
    chk("busy_after_A5", bus.busy, 0);
    chk("dataOut_A5", bus.dataOut, 8'hA5);
    idle(10);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    idle(20);
    chk("dataOut_b2b_last", bus.dataOut, 8'h55);

    bus.uart_rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(30);
    chk("busy_after_glitch", bus.busy, 0);
    send(8'h3C, 1'b1, 1'b0);
    idle(20);

    send(8'h81, 1'b0, 1'b0);
    bus.uart_rx = 1'b0;
    repeat (40) @(negedge clock);
    chk("busy_during_break", bus.busy, 1);
    idle(20);
    chk("busy_after_break", bus.busy, 0);
    chk("dataOut_kept_after_ferr", bus.dataOut, 8'h3C);
    send(8'h12, 1'b1, 1'b0);
    idle(20);

    c3 = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    bus.uart_rx = c3[4];
    repeat (8) @(negedge clock);
    reset = 1'b1;
    bus.uart_rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_good = 8'h00;
    idle(40);
    chk("dataOut_after_midframe_reset", bus.dataOut, 8'h00);
    chk("busy_after_midframe_reset", bus.busy, 0);
    send(8'h7E, 1'b1, 1'b0);
    idle(20);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b0);
    idle(20);
    chk("dataOut_after_parity_err", bus.dataOut, 8'h07);
`endif

    for (int f = 0; f < 12; f++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      send(d, stop, par);
      gap = stop ? $urandom_range(0, 20) : $urandom_range(4, 24);
      idle(gap);
    end
    idle(3 * CPB);
    chk("dataOut_final", bus.dataOut, last_good);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8 data bits, LSB first, 1 stop bit, no parity by default (8N1); receive-side counterpart of the team's UART transmitter.
- Synchronizes the asynchronous serial input, detects the start bit and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the board RX pin and the byte-consuming logic (echo/loopback, command parser).

Parameters:
- CLOCK_SPEED, 12000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in baud.
- Derived localparam CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE (integer division).
- Derived localparam HALF_BIT = CLKS_PER_BIT / 2.
- CLKS_PER_BIT >= 4 is required; elaboration-time check fails otherwise.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line, idle high.
- dataOut  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse: dataOut was updated with a new byte.
- frameError  output  1  one-cycle pulse: stop bit sampled low.
- parityError  output  1  one-cycle pulse: parity mismatch (see Optional Feature).
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (synchronous, reset high at posedge): state=IDLE, counters=0, both synchronizer flops=1, dataOut=8'h00, valid=0, frameError=0, parityError=0, busy=0. Reset mid-frame abandons the frame with no strobe.
- Synchronizer: 2 flops on uart_rx; rxs = second flop. All decisions use rxs only. Raw input-to-rxs delay is 2 cycles.
- IDLE: when rxs==0, go to START and clear bit counter and clock counter.
- START: count HALF_BIT cycles, then sample rxs.
  - rxs==1: glitch/false start; return to IDLE with no strobe.
  - rxs==0: go to DATA with clock counter=0.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit[bitIdx], LSB first, bitIdx 0..7. After bit 7, go to STOP (or PARITY if the feature is enabled).
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs==1: dataOut <= shift register; valid=1 for exactly the next cycle; go to IDLE.
  - rxs==0: frameError=1 for one cycle; dataOut unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. Break conditions (line held low) therefore produce exactly one frameError, not repeated frames.
- Strobes valid, frameError and parityError are mutually exclusive and never high on two consecutive cycles.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit sample point. IDLE is re-entered mid-stop-bit, so no idle gap is required.
- Latency: valid is asserted 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling edge on uart_rx.
- No backpressure: the consumer must capture dataOut on valid. dataOut holds its value until the next good frame.
- Counters are 32-bit. Each compare uses == against (CLKS_PER_BIT-1) or (HALF_BIT-1), then resets to 0. No wrap-around is possible.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled one CLKS_PER_BIT after bit 7.
  - Even parity is expected: XOR of 8 data bits and the parity bit must be 0.
  - On mismatch with a good stop bit: parityError pulses one cycle, valid is not asserted, dataOut is unchanged.
  - A bad stop bit takes priority: only frameError pulses.
- Not defined: parityError is tied to 0 and the frame is 8N1.

Test Plan (CLOCK_SPEED=1600, BAUD_RATE=100 -> 16 clocks/bit):
- Send 8'hA5 as 8N1 after reset -> exactly one valid pulse, dataOut=8'hA5, frameError never high, busy low within 16 cycles after valid.
- Send 8'h00, 8'hFF, 8'h55 back-to-back with zero idle gap -> three valid pulses, ~160 cycles apart, values in order.
- Pull uart_rx low for 5 cycles, then high -> no strobe, busy returns low, next frame 8'h3C is received correctly.
- Send 8'h81 with stop bit forced low, then hold low 40 cycles -> one frameError pulse, dataOut keeps its prior value, no valid; a subsequent 8'h12 is received correctly.
- Assert reset for 1 cycle during bit 4 of 8'hC3 -> no strobe, dataOut=8'h00; a following 8'h7E is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 1 -> valid, dataOut=8'h07; send 8'h07 with parity bit 0 -> parityError pulse only, dataOut stays 8'h07.
